// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

  // Natural alignment: the lane must be a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      SZ_D:    return |lane;
      default: return 1'b0;
    endcase
  endfunction

  // (1<<size) bytes starting at lane; bytes past lane 7 fall off the top.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << size)) - 16'd1;
    m = m << lane;
    return m[7:0];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data/mask placement and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [63:0] wdata_sh_c,
  output logic [7:0]  wmask_c,
  output logic [63:0] rdata_c
);

  logic [63:0] rsh;

  always_comb begin
    wdata_sh_c = wdata << {lane, 3'b000};
    wmask_c    = byte_mask(size, lane);
    rsh        = rword >> {lane, 3'b000};
    rdata_c    = rsh;
    case (size)
      SZ_B:    rdata_c = uns ? 64'(rsh[7:0])  : {{56{rsh[7]}},  rsh[7:0]};
      SZ_H:    rdata_c = uns ? 64'(rsh[15:0]) : {{48{rsh[15]}}, rsh[15:0]};
      SZ_W:    rdata_c = uns ? 64'(rsh[31:0]) : {{32{rsh[31]}}, rsh[31:0]};
      default: rdata_c = rsh;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a 64-bit-wide RAM with programmable latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 3;
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic [63:0] mem [DEPTH];

  logic [2:0]    lane_c;
  logic [AW-1:0] idx_c;
  logic          err_c;
  logic          mem_we_c;
  logic [63:0]   rword_c;
  logic [63:0]   wdata_sh_c;
  logic [7:0]    wmask_c;
  logic [63:0]   wbits_c;
  logic [63:0]   ld_data_c;

  assign lane_c  = addr_q[2:0];
  assign idx_c   = addr_q[3 +: AW];
  assign err_c   = misaligned(size_q, lane_c) || (addr_q >= ADDR_LIMIT);
  assign rword_c = mem[idx_c];

  dmem_lane_align u_align (
    .wdata      (wdata_q),
    .rword      (rword_c),
    .lane       (lane_c),
    .size       (size_q),
    .uns        (uns_q),
    .wdata_sh_c (wdata_sh_c),
    .wmask_c    (wmask_c),
    .rdata_c    (ld_data_c)
  );

  // Expand the byte mask to a bit mask for the read-modify-write.
  always_comb begin
    wbits_c = '0;
    for (int i = 0; i < 8; i++) begin
      wbits_c[8*i +: 8] = {8{wmask_c[i]}};
    end
  end

  assign mem_we_c = (state_q == EXEC) && we_q && !err_c;

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= (rword_c & ~wbits_c) | (wdata_sh_c & wbits_c);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? EXEC : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      EXEC: begin
        rvalid_d = 1'b1;
        rerr_d   = err_c;
        rdata_d  = (err_c || we_q) ? 64'd0 : ld_data_c;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 64'd0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  ref_mem [DEPTH*8];
  logic [63:0] exp_rd_g;
  logic        exp_err_g;
  logic [63:0] got_rdata;
  logic        got_err;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic mdl_err(input logic [1:0] size, input logic [63:0] addr);
    logic [63:0] n;
    n = 64'd1 << size;
    return ((addr % n) != 64'd0) || (addr >= LIMIT);
  endfunction

  function automatic logic [63:0] mdl_load(input logic [1:0] size, input logic uns,
                                          input logic [63:0] addr);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
    if (n < 8 && !uns && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  // Compute the expected response and commit a legal store to the model.
  task automatic set_exp(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
    exp_err_g = mdl_err(size, addr);
    exp_rd_g  = (exp_err_g || we) ? 64'd0 : mdl_load(size, uns, addr);
    if (we && !exp_err_g)
      for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  task automatic scramble();
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
  endtask

  task automatic accept(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
    int k;
    set_exp(we, size, uns, addr, wdata);
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    k = 0;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    scramble();
  endtask

  task automatic await_resp();
    int k;
    k = 0;
    while (!resp_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("latency", 64'(k), 64'(LAT));
    check("rdata", resp_rdata, exp_rd_g);
    check("err", 64'(resp_err), 64'(exp_err_g));
    got_rdata = resp_rdata;
    got_err   = resp_err;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic op(input logic we, input logic [1:0] size, input logic uns,
                    input logic [63:0] addr, input logic [63:0] wdata);
    accept(we, size, uns, addr, wdata);
    await_resp();
    consume();
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] word4;
    int r;

    // Reset state, with a request presented that must not be taken.
    #2 rst = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h10;
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("post_rst_idle_ready", 64'(req_ready), 64'd1);
    check("post_rst_no_resp", 64'(resp_valid), 64'd0);

    // Known contents for the words the bench reads.
    for (int i = 0; i < 16; i++) op(1'b1, 2'd3, 1'b0, 64'(i * 8), {$urandom, $urandom});
    op(1'b1, 2'd3, 1'b0, LIMIT - 64'd16, {$urandom, $urandom});
    op(1'b1, 2'd3, 1'b0, LIMIT - 64'd8, 64'h8000_0001_F234_5678);

    op(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788);
    op(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
    check("t1_ld", got_rdata, 64'h1122334455667788);

    op(1'b1, 2'd0, 1'b0, 64'h13, 64'hAB);
    op(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
    check("t2_ld", got_rdata, 64'h11223344AB667788);
    op(1'b0, 2'd0, 1'b0, 64'h13, 64'd0);
    check("t2_lb", got_rdata, 64'hFFFFFFFFFFFFFFAB);
    op(1'b0, 2'd0, 1'b1, 64'h13, 64'd0);
    check("t2_lbu", got_rdata, 64'h00000000000000AB);

    op(1'b0, 2'd1, 1'b0, 64'h11, 64'd0);
    check("t3_lh_err", 64'(got_err), 64'd1);
    check("t3_lh_rdata", got_rdata, 64'd0);
    op(1'b1, 2'd2, 1'b0, 64'h12, 64'hDEADBEEF);
    check("t3_sw_err", 64'(got_err), 64'd1);
    op(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
    check("t3_unchanged", got_rdata, 64'h11223344AB667788);

    op(1'b0, 2'd3, 1'b0, LIMIT, 64'd0);
    check("t4_oor_err", 64'(got_err), 64'd1);
    op(1'b0, 2'd2, 1'b0, LIMIT - 64'd4, 64'd0);
    check("t4_lw_err", 64'(got_err), 64'd0);
    check("t4_lw_data", got_rdata, 64'hFFFFFFFF80000001);

    // Back-pressure: response held, second request waits.
    accept(1'b0, 2'd3, 1'b0, 64'h18, 64'd0);
    await_resp();
    drive(1'b0, 2'd2, 1'b1, 64'h8, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_hold_valid", 64'(resp_valid), 64'd1);
      check("t5_hold_rdata", resp_rdata, exp_rd_g);
      check("t5_hold_err", 64'(resp_err), 64'(exp_err_g));
      check("t5_hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("t5_released_valid", 64'(resp_valid), 64'd0);
    check("t5_released_ready", 64'(req_ready), 64'd1);
    set_exp(1'b0, 2'd2, 1'b1, 64'h8, 64'd0);
    @(posedge clk); #1;
    check("t5_second_accepted", 64'(req_ready), 64'd0);
    scramble();
    await_resp();
    consume();

    // Reset during WAIT drops the store.
    op(1'b0, 2'd3, 1'b0, 64'h20, 64'd0);
    word4 = got_rdata;
    @(negedge clk);
    drive(1'b1, 2'd3, 1'b0, 64'h20, 64'h5);
    @(posedge clk); #1;
    scramble();
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 64'(resp_valid), 64'd0);
    check("t6_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    check("t6_rst_still_no_resp", 64'(resp_valid), 64'd0);
    rst = 1'b1;
    op(1'b0, 2'd3, 1'b0, 64'h20, 64'd0);
    check("t6_no_write", got_rdata, word4);

    // Random mix over initialised words, the top boundary and far addresses.
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = 64'($urandom_range(0, 127));
      else if (r < 9) a = LIMIT - 64'd16 + 64'($urandom_range(0, 31));
      else            a = {$urandom, $urandom};
      op(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
